pairing_job_scheduler: RTL and testbench



---
 rtl/pairing_job_scheduler_if.sv | 51 +++++
 rtl/pairing_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_pairing_job_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pairing_job_scheduler_if.sv
// Handshake/bus bundle between the pairing job scheduler, its requesters,
// the shared pairing engine and the response consumer.
// master: scheduler side. slave: requesters + engine + consumer side.
interface pairing_job_scheduler_if #(
    parameter int M    = 97,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    localparam int OPW = 2 * M;
    localparam int RW  = 12 * M;

    // requester side: requester k occupies bits [k*OPW +: OPW]
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_x1;
    logic [NREQ*OPW-1:0] req_y1;
    logic [NREQ*OPW-1:0] req_x2;
    logic [NREQ*OPW-1:0] req_y2;

    // engine side
    logic                eng_rst;
    logic [OPW-1:0]      eng_x1;
    logic [OPW-1:0]      eng_y1;
    logic [OPW-1:0]      eng_x2;
    logic [OPW-1:0]      eng_y2;
    logic                eng_done;
    logic [RW-1:0]       eng_out;

    // response side and status
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [RW-1:0]       rsp_data;
    logic                rsp_err;
    logic                busy;
    logic [15:0]         jobs_done;

    modport master (
        input  req_valid, req_x1, req_y1, req_x2, req_y2,
        input  eng_done, eng_out, rsp_ready,
        output req_ready, eng_rst, eng_x1, eng_y1, eng_x2, eng_y2,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy, jobs_done
    );

    modport slave (
        output req_valid, req_x1, req_y1, req_x2, req_y2,
        output eng_done, eng_out, rsp_ready,
        input  req_ready, eng_rst, eng_x1, eng_y1, eng_x2, eng_y2,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy, jobs_done
    );
endinterface

// File: rtl/pairing_job_scheduler.sv
// Round-robin shares one Tate pairing engine among NREQ requesters; returns result tagged with id.
// Latency: accept at T, engine released T+3, response the cycle after eng_done (or TIMEOUT RUN cycles).
// Backpressure: response held stable in DRAIN until rsp_ready; no new accept until the handshake.
// Ports: clk, reset (async, active-high), bus (master modport: requests, engine, response, status).
module pairing_job_scheduler #(
    parameter int M       = 97,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 2**20
) (
    input logic                   clk,
    input logic                   reset,
    pairing_job_scheduler_if.master bus
);
    localparam int OPW = 2 * M;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t          state, state_n;
    logic            load_cnt;
    logic [31:0]     wd_cnt;
    logic [IDW-1:0]  last;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win;
    logic            found;
    logic [OPW-1:0]  sel_x1, sel_y1, sel_x2, sel_y2;

    logic            accept, run_done, run_timeout, rsp_fire;

    // Round-robin search: first pass covers indices above last, second pass
    // wraps to 0..last, so the search runs upward from last+1 modulo NREQ.
    always_comb begin
        grant  = '0;
        win    = '0;
        found  = 1'b0;
        sel_x1 = '0;
        sel_y1 = '0;
        sel_x2 = '0;
        sel_y2 = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && j > int'(last)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                win      = IDW'(j);
                sel_x1   = bus.req_x1[j*OPW +: OPW];
                sel_y1   = bus.req_y1[j*OPW +: OPW];
                sel_x2   = bus.req_x2[j*OPW +: OPW];
                sel_y2   = bus.req_y2[j*OPW +: OPW];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && j <= int'(last)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                win      = IDW'(j);
                sel_x1   = bus.req_x1[j*OPW +: OPW];
                sel_y1   = bus.req_y1[j*OPW +: OPW];
                sel_x2   = bus.req_x2[j*OPW +: OPW];
                sel_y2   = bus.req_y2[j*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        run_done      = 1'b0;
        run_timeout   = 1'b0;
        rsp_fire      = 1'b0;
        // reset is folded in so no grant is advertised while reset is held
        bus.req_ready = (state == IDLE && !reset) ? grant : '0;
        bus.eng_rst   = (state != RUN);
        bus.rsp_valid = (state == DRAIN);
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (found) begin
                    accept  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                // two cycles of eng_rst for the engine's internal reset pipeline
                if (load_cnt) state_n = RUN;
            end
            RUN: begin
                // completion has priority over a coincident watchdog expiry
                if (bus.eng_done) begin
                    run_done = 1'b1;
                    state_n  = DRAIN;
                end else if (wd_cnt == 32'(TIMEOUT - 1)) begin
                    run_timeout = 1'b1;
                    state_n     = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.rsp_ready) begin
                    rsp_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt      <= 1'b0;
            wd_cnt        <= '0;
            last          <= IDW'(NREQ - 1);
            bus.eng_x1    <= '0;
            bus.eng_y1    <= '0;
            bus.eng_x2    <= '0;
            bus.eng_y2    <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.jobs_done <= '0;
        end else begin
            if (accept) begin
                bus.eng_x1 <= sel_x1;
                bus.eng_y1 <= sel_y1;
                bus.eng_x2 <= sel_x2;
                bus.eng_y2 <= sel_y2;
                bus.rsp_id <= win;
                last       <= win;
                load_cnt   <= 1'b0;
            end
            if (state == LOAD) begin
                load_cnt <= 1'b1;
                wd_cnt   <= '0;
            end
            if (state == RUN) wd_cnt <= wd_cnt + 32'd1;
            if (run_done) begin
                bus.rsp_data <= bus.eng_out;
                bus.rsp_err  <= 1'b0;
            end
            if (run_timeout) begin
                bus.rsp_data <= '0;
                bus.rsp_err  <= 1'b1;
            end
            if (rsp_fire && bus.jobs_done != 16'hFFFF)
                bus.jobs_done <= bus.jobs_done + 16'd1;
        end
    end
endmodule

// File: tb/tb_pairing_job_scheduler.sv
module tb_pairing_job_scheduler;
    localparam int M       = 97;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;
    localparam int OPW     = 2 * M;
    localparam int RW      = 12 * M;
    localparam int NEVER   = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pairing_job_scheduler_if #(.M(M), .NREQ(NREQ), .IDW(IDW)) bus();

    pairing_job_scheduler #(.M(M), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // requester operand storage
    logic [OPW-1:0] ox1 [NREQ];
    logic [OPW-1:0] oy1 [NREQ];
    logic [OPW-1:0] ox2 [NREQ];
    logic [OPW-1:0] oy2 [NREQ];
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            bus.req_x1[k*OPW +: OPW] = ox1[k];
            bus.req_y1[k*OPW +: OPW] = oy1[k];
            bus.req_x2[k*OPW +: OPW] = ox2[k];
            bus.req_y2[k*OPW +: OPW] = oy2[k];
        end
    end

    function automatic logic [RW-1:0] pair_fn(logic [OPW-1:0] x1, logic [OPW-1:0] y1,
                                              logic [OPW-1:0] x2, logic [OPW-1:0] y2);
        return {x1 ^ y2, y1 + x2, x1, y1, x2, ~y2};
    endfunction

    function automatic logic [OPW-1:0] make_op(int k, int j, int w);
        logic [OPW-1:0] v;
        v = '0;
        v[31:0] = 32'(k * 4096 + j * 16 + w) ^ 32'hA5C3_0000;
        v[OPW-1 -: 32] = ~v[31:0];
        return v;
    endfunction

    // engine model: done rises done_at cycles into RUN, drops when eng_rst returns
    int   run_cnt = 0;
    int   done_at = NEVER;
    logic stale_done = 1'b0;
    always @(posedge clk) begin
        if (bus.eng_rst) run_cnt <= 0;
        else             run_cnt <= run_cnt + 1;
    end
    assign bus.eng_done = (!bus.eng_rst && run_cnt >= done_at) || stale_done;
    assign bus.eng_out  = pair_fn(bus.eng_x1, bus.eng_y1, bus.eng_x2, bus.eng_y2);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [RW-1:0]  data;
        logic           err;
    } rsp_t;

    logic [NREQ-1:0] grant_q[$];
    rsp_t            rsp_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk_data(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got low64 %0h expected low64 %0h (cycle %0d)",
                     name, act[63:0], exp[63:0], cyc);
        end
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (|bus.req_ready) begin
                if (grant_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_grant: got %b expected none", bus.req_ready);
                end else begin
                    chk("grant", 64'(bus.req_ready), 64'(grant_q.pop_front()));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got id %0d expected none", bus.rsp_id);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk_data("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(int k, int j);
        ox1[k] = make_op(k, j, 1);
        oy1[k] = make_op(k, j, 2);
        ox2[k] = make_op(k, j, 3);
        oy2[k] = make_op(k, j, 4);
    endtask

    task automatic expect_job(int k, logic err);
        grant_q.push_back(NREQ'(1) << k);
        if (err) rsp_q.push_back('{id: IDW'(k), data: '0, err: 1'b1});
        else     rsp_q.push_back('{id: IDW'(k), data: pair_fn(ox1[k], oy1[k], ox2[k], oy2[k]), err: 1'b0});
    endtask

    task automatic wait_grant(string name, output int t);
        t = -1;
        for (int n = 0; n < 300 && t < 0; n++) begin
            @(negedge clk);
            if (|bus.req_ready) t = cyc;
        end
        if (t < 0) begin
            total++; bad++;
            $display("FAIL %s: got no grant expected one within 300 cycles", name);
        end
    endtask

    task automatic wait_rsp(string name, output int t);
        t = -1;
        for (int n = 0; n < 300 && t < 0; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) t = cyc;
        end
        if (t < 0) begin
            total++; bad++;
            $display("FAIL %s: got no rsp_valid expected one within 300 cycles", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int t, r;
        logic [IDW-1:0] hid;
        logic [RW-1:0]  hdata;
        logic           herr;

        for (int k = 0; k < NREQ; k++) set_ops(k, 0);
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;

        // reset values, with all requesters asserting valid
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_eng_rst", 64'(bus.eng_rst), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk_data("rst_rsp_data", bus.rsp_data, '0);
        chk("rst_eng_x1", 64'(bus.eng_x1[63:0]), 64'd0);
        chk("rst_jobs_done", 64'(bus.jobs_done), 64'd0);
        step();
        reset = 1'b0;

        // round-robin: all four held valid for 8 jobs, order 0,1,2,3,0,1,2,3
        done_at = 4;
        for (int j = 0; j < 8; j++) expect_job(j % NREQ, 1'b0);
        for (int j = 0; j < 8; j++) wait_grant("rr_grant", t);
        step();
        bus.req_valid = '0;
        wait_rsp("rr_rsp", r);
        @(negedge clk);
        chk("rr_jobs_done", 64'(bus.jobs_done), 64'd8);

        // single job on requester 2, engine done 50 cycles into RUN
        done_at = 49;
        set_ops(2, 1);
        expect_job(2, 1'b0);
        step();
        bus.req_valid = 4'b0100;
        wait_grant("single_grant_wait", t);
        chk("single_req_ready", 64'(bus.req_ready), 64'h4);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_eng_rst_t1", 64'(bus.eng_rst), 64'd1);
        @(negedge clk);
        chk("single_eng_rst_t2", 64'(bus.eng_rst), 64'd1);
        @(negedge clk);
        chk("single_eng_rst_t3", 64'(bus.eng_rst), 64'd0);
        wait_rsp("single_rsp", r);
        chk("single_rsp_latency", 64'(r - t), 64'd53);
        @(negedge clk);
        chk("single_rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
        chk("single_busy_after", 64'(bus.busy), 64'd0);
        chk("single_jobs_done", 64'(bus.jobs_done), 64'd9);

        // backpressure: requester 1 runs, requester 3 waits during the stall
        done_at = 10;
        set_ops(1, 2);
        set_ops(3, 2);
        expect_job(1, 1'b0);
        expect_job(3, 1'b0);
        step();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        wait_grant("bp_grant1", t);
        step();
        bus.req_valid = 4'b1000;
        wait_rsp("bp_rsp", r);
        hid = bus.rsp_id;
        hdata = bus.rsp_data;
        herr = bus.rsp_err;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rsp_id_stable", 64'(bus.rsp_id), 64'(hid));
            chk_data("bp_rsp_data_stable", bus.rsp_data, hdata);
            chk("bp_rsp_err_stable", 64'(bus.rsp_err), 64'(herr));
            chk("bp_eng_rst", 64'(bus.eng_rst), 64'd1);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_valid", 64'(bus.rsp_valid), 64'd1);
        @(negedge clk);
        chk("bp_accept_next", 64'(bus.req_ready), 64'h8);
        step();
        bus.req_valid = '0;
        wait_rsp("bp_rsp2", r);
        @(negedge clk);
        chk("bp_jobs_done", 64'(bus.jobs_done), 64'd11);

        // watchdog: engine never completes
        done_at = NEVER;
        set_ops(0, 3);
        expect_job(0, 1'b1);
        step();
        bus.req_valid = 4'b0001;
        wait_grant("wd_grant", t);
        step();
        bus.req_valid = '0;
        wait_rsp("wd_rsp", r);
        chk("wd_latency", 64'(r - t), 64'(3 + TIMEOUT));
        chk("wd_rsp_err_now", 64'(bus.rsp_err), 64'd1);

        // done on exactly the last watchdog count: done wins, next job normal
        done_at = TIMEOUT - 1;
        set_ops(1, 4);
        expect_job(1, 1'b0);
        step();
        bus.req_valid = 4'b0010;
        wait_grant("col_grant", t);
        step();
        bus.req_valid = '0;
        wait_rsp("col_rsp", r);
        chk("col_latency", 64'(r - t), 64'(3 + TIMEOUT));
        chk("col_rsp_err_now", 64'(bus.rsp_err), 64'd0);
        @(negedge clk);
        chk("col_jobs_done", 64'(bus.jobs_done), 64'd13);

        // reset 10 cycles into RUN aborts the job without a response
        done_at = NEVER;
        set_ops(2, 5);
        grant_q.push_back(4'b0100);
        step();
        bus.req_valid = 4'b0100;
        wait_grant("mid_grant", t);
        step();
        bus.req_valid = '0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_eng_rst", 64'(bus.eng_rst), 64'd1);
        chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_jobs_done", 64'(bus.jobs_done), 64'd0);
        chk("mid_busy", 64'(bus.busy), 64'd0);
        step();
        reset = 1'b0;
        stale_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_busy", 64'(bus.busy), 64'd0);
            chk("stale_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end
        step();
        stale_done = 1'b0;
        done_at = 5;
        for (int k = 0; k < NREQ; k++) set_ops(k, 6);
        expect_job(0, 1'b0);
        bus.req_valid = '1;
        wait_grant("post_rst_grant", t);
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = '0;
        wait_rsp("post_rst_rsp", r);
        @(negedge clk);
        chk("post_rst_jobs_done", 64'(bus.jobs_done), 64'd1);

        repeat (3) @(negedge clk);
        chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
